// File: rtl/commit_log_serializer.sv
// Commit-log serializer: captures two register-file write ports into an entry FIFO
// and streams each entry as DPI_WIDTH-bit words, key words first, LSB word first.
module commit_log_serializer #(
   parameter int DPI_WIDTH       = 32,
   parameter int KEY_WIDTH       = 64,
   parameter int VALUE_WIDTH     = 128,
   parameter int MAX_ENTRY_COUNT = 16
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic [KEY_WIDTH-1:0]               wa1_i,
   input  logic [VALUE_WIDTH-1:0]             wd1_i,
   input  logic                               we1_i,
   input  logic [KEY_WIDTH-1:0]               wa2_i,
   input  logic [VALUE_WIDTH-1:0]             wd2_i,
   input  logic                               we2_i,
   input  logic                               clear_i,
   output logic [DPI_WIDTH-1:0]               word_o,
   output logic                               word_valid_o,
   input  logic                               word_ready_i,
   output logic                               word_last_o,
   output logic [$clog2(MAX_ENTRY_COUNT):0]   count_o,
   output logic                               overflow_o
);

   localparam int KW   = KEY_WIDTH / DPI_WIDTH;
   localparam int VW   = VALUE_WIDTH / DPI_WIDTH;
   localparam int PW   = $clog2(MAX_ENTRY_COUNT);
   localparam int CW   = PW + 1;
   localparam int MAXW = (KW > VW) ? KW : VW;
   localparam int IW   = (MAXW > 1) ? $clog2(MAXW) : 1;

   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [IW-1:0] IDX_ONE = IW'(1);

   if ((KEY_WIDTH % DPI_WIDTH) != 0) begin : g_key_width_chk
      $error("KEY_WIDTH must be a multiple of DPI_WIDTH");
   end
   if ((VALUE_WIDTH % DPI_WIDTH) != 0) begin : g_value_width_chk
      $error("VALUE_WIDTH must be a multiple of DPI_WIDTH");
   end
   if ((MAX_ENTRY_COUNT < 2) || ((MAX_ENTRY_COUNT & (MAX_ENTRY_COUNT - 1)) != 0)) begin : g_depth_chk
      $error("MAX_ENTRY_COUNT must be a power of 2 and at least 2");
   end

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_KEY   = 2'd1,
      ST_VALUE = 2'd2
   } state_t;

   logic [KEY_WIDTH-1:0]   key_mem_r [MAX_ENTRY_COUNT];
   logic [VALUE_WIDTH-1:0] val_mem_r [MAX_ENTRY_COUNT];

   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic          overflow_r;
   state_t        state_r;
   logic [IW-1:0] idx_r;

   logic [CW-1:0] free_s;
   logic          push1_s;
   logic          push2_s;
   logic          drop_s;
   logic          pop_s;
   logic [PW-1:0] wr_ptr2_s;
   logic [PW-1:0] rd_next_s;
   logic [IW-1:0] idx_inc_s;

   function automatic logic [DPI_WIDTH-1:0] key_word(input logic [KEY_WIDTH-1:0] k,
                                                      input logic [IW-1:0] i);
      return k[int'(i)*DPI_WIDTH +: DPI_WIDTH];
   endfunction

   function automatic logic [DPI_WIDTH-1:0] val_word(input logic [VALUE_WIDTH-1:0] v,
                                                      input logic [IW-1:0] i);
      return v[int'(i)*DPI_WIDTH +: DPI_WIDTH];
   endfunction

   // Admission uses the space free before this edge; a same-edge pop does not count.
   always_comb begin
      free_s  = CW'(MAX_ENTRY_COUNT) - count_r;
      push1_s = we1_i && (free_s != {CW{1'b0}});
      if (push1_s) begin
         push2_s = we2_i && (free_s >= CW'(2));
      end else begin
         push2_s = we2_i && (free_s != {CW{1'b0}});
      end
      drop_s    = (we1_i && !push1_s) || (we2_i && !push2_s);
      pop_s     = (state_r == ST_VALUE) && word_ready_i && (idx_r == IW'(VW - 1));
      wr_ptr2_s = push1_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
      rd_next_s = rd_ptr_r + PTR_ONE;
      idx_inc_s = idx_r + IDX_ONE;
   end

   // Entry storage; port-1 lands ahead of port-2 when both are admitted.
   always_ff @(posedge clk_i) begin
      if (rst_ni && !clear_i) begin
         if (push1_s) begin
            key_mem_r[wr_ptr_r] <= wa1_i;
            val_mem_r[wr_ptr_r] <= wd1_i;
         end
         if (push2_s) begin
            key_mem_r[wr_ptr2_s] <= wa2_i;
            val_mem_r[wr_ptr2_s] <= wd2_i;
         end
      end
   end

   // FIFO pointers, occupancy and sticky overflow.
   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
         wr_ptr_r   <= {PW{1'b0}};
         rd_ptr_r   <= {PW{1'b0}};
         count_r    <= {CW{1'b0}};
         overflow_r <= 1'b0;
      end else begin
         wr_ptr_r   <= wr_ptr_r + PW'(push1_s) + PW'(push2_s);
         rd_ptr_r   <= pop_s ? rd_next_s : rd_ptr_r;
         count_r    <= count_r + CW'(push1_s) + CW'(push2_s) - CW'(pop_s);
         overflow_r <= overflow_r | drop_s;
      end
   end

   // Stream FSM; word/last are loaded with the word the next state will present.
   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
         state_r      <= ST_IDLE;
         idx_r        <= {IW{1'b0}};
         word_o       <= {DPI_WIDTH{1'b0}};
         word_valid_o <= 1'b0;
         word_last_o  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (count_r != {CW{1'b0}}) begin
                  state_r      <= ST_KEY;
                  idx_r        <= {IW{1'b0}};
                  word_o       <= key_word(key_mem_r[rd_ptr_r], {IW{1'b0}});
                  word_valid_o <= 1'b1;
                  word_last_o  <= 1'b0;
               end else begin
                  word_valid_o <= 1'b0;
                  word_last_o  <= 1'b0;
               end
            end
            ST_KEY: begin
               if (word_ready_i) begin
                  if (idx_r == IW'(KW - 1)) begin
                     state_r     <= ST_VALUE;
                     idx_r       <= {IW{1'b0}};
                     word_o      <= val_word(val_mem_r[rd_ptr_r], {IW{1'b0}});
                     word_last_o <= (VW == 1);
                  end else begin
                     idx_r       <= idx_inc_s;
                     word_o      <= key_word(key_mem_r[rd_ptr_r], idx_inc_s);
                     word_last_o <= 1'b0;
                  end
               end else begin
                  word_o <= word_o;
               end
            end
            ST_VALUE: begin
               if (word_ready_i) begin
                  if (idx_r == IW'(VW - 1)) begin
                     // Chain straight into the next entry so there is no bubble.
                     if (count_r > CW'(1)) begin
                        state_r     <= ST_KEY;
                        idx_r       <= {IW{1'b0}};
                        word_o      <= key_word(key_mem_r[rd_next_s], {IW{1'b0}});
                        word_last_o <= 1'b0;
                     end else begin
                        state_r      <= ST_IDLE;
                        idx_r        <= {IW{1'b0}};
                        word_o       <= {DPI_WIDTH{1'b0}};
                        word_valid_o <= 1'b0;
                        word_last_o  <= 1'b0;
                     end
                  end else begin
                     idx_r       <= idx_inc_s;
                     word_o      <= val_word(val_mem_r[rd_ptr_r], idx_inc_s);
                     word_last_o <= (idx_inc_s == IW'(VW - 1));
                  end
               end else begin
                  word_o <= word_o;
               end
            end
            default: begin
               state_r      <= ST_IDLE;
               idx_r        <= {IW{1'b0}};
               word_o       <= {DPI_WIDTH{1'b0}};
               word_valid_o <= 1'b0;
               word_last_o  <= 1'b0;
            end
         endcase
      end
   end

   assign count_o    = count_r;
   assign overflow_o = overflow_r;

endmodule

// File: tb/tb_commit_log_serializer.sv
// Directed bench for commit_log_serializer: six scenarios with hand-derived expectations.
module tb_commit_log_serializer;

   logic         clk;
   logic         rst_n;
   logic [63:0]  wa1;
   logic [127:0] wd1;
   logic         we1;
   logic [63:0]  wa2;
   logic [127:0] wd2;
   logic         we2;
   logic         clear;
   logic [31:0]  word;
   logic         word_valid;
   logic         word_ready;
   logic         word_last;
   logic [4:0]   count;
   logic         overflow;

   int total = 0;
   int bad   = 0;

   logic [31:0]  t1_exp [6];
   logic [63:0]  ka;
   logic [127:0] va;
   logic [63:0]  kb;
   logic [127:0] vb;

   commit_log_serializer #(
      .DPI_WIDTH(32), .KEY_WIDTH(64), .VALUE_WIDTH(128), .MAX_ENTRY_COUNT(16)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .wa1_i(wa1), .wd1_i(wd1), .we1_i(we1),
      .wa2_i(wa2), .wd2_i(wd2), .we2_i(we2),
      .clear_i(clear),
      .word_o(word), .word_valid_o(word_valid), .word_ready_i(word_ready),
      .word_last_o(word_last), .count_o(count), .overflow_o(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_word(input string tag, input logic [31:0] w, input logic l);
      chk({tag, "_valid"}, {127'd0, word_valid}, 128'd1);
      chk({tag, "_word"}, {96'd0, word}, {96'd0, w});
      chk({tag, "_last"}, {127'd0, word_last}, {127'd0, l});
   endtask

   // Word i of an entry: two key words then four value words, LSB word first.
   function automatic logic [31:0] ent_word(input logic [63:0] k, input logic [127:0] v, input int i);
      if (i < 2) return k[i*32 +: 32];
      else       return v[(i-2)*32 +: 32];
   endfunction

   function automatic logic [127:0] t4_val(input int e);
      logic [31:0] b;
      b = 32'hD000_0000 + 32'(e * 16);
      return {b + 32'd3, b + 32'd2, b + 32'd1, b};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; we1 = 1'b0; we2 = 1'b0; clear = 1'b0; word_ready = 1'b0;
      wa1 = 64'd0; wd1 = 128'd0; wa2 = 64'd0; wd2 = 128'd0;
      tick(); tick();
      chk("rst_count", {123'd0, count}, 128'd0);
      chk("rst_ovf", {127'd0, overflow}, 128'd0);
      chk("rst_valid", {127'd0, word_valid}, 128'd0);
      chk("rst_last", {127'd0, word_last}, 128'd0);
      chk("rst_word", {96'd0, word}, 128'd0);
      rst_n = 1'b1;

      // 1: single push, ready high
      t1_exp = '{32'd5, 32'd1, 32'd1, 32'd2, 32'd3, 32'd4};
      wa1 = 64'h00000001_00000005;
      wd1 = 128'h00000004_00000003_00000002_00000001;
      we1 = 1'b1; word_ready = 1'b1;
      tick();
      we1 = 1'b0;
      chk("t1_count_push", {123'd0, count}, 128'd1);
      chk("t1_valid_pre", {127'd0, word_valid}, 128'd0);
      tick();
      for (int i = 0; i < 6; i++) begin
         chk_word($sformatf("t1_w%0d", i), t1_exp[i], (i == 5));
         tick();
      end
      chk("t1_valid_end", {127'd0, word_valid}, 128'd0);
      chk("t1_count_end", {123'd0, count}, 128'd0);

      // 2: dual push at one edge, no bubble between entries
      ka = 64'h10; va = {32'h14, 32'h13, 32'h12, 32'h11};
      kb = 64'h20; vb = {32'h24, 32'h23, 32'h22, 32'h21};
      wa1 = ka; wd1 = va; wa2 = kb; wd2 = vb; we1 = 1'b1; we2 = 1'b1;
      tick();
      we1 = 1'b0; we2 = 1'b0;
      chk("t2_count", {123'd0, count}, 128'd2);
      tick();
      for (int i = 0; i < 12; i++) begin
         chk_word($sformatf("t2_w%0d", i),
                  (i < 6) ? ent_word(ka, va, i) : ent_word(kb, vb, i - 6), (i == 5) || (i == 11));
         tick();
      end
      chk("t2_valid_end", {127'd0, word_valid}, 128'd0);
      chk("t2_count_end", {123'd0, count}, 128'd0);

      // 3: back-pressure on key word 1
      ka = 64'h00000031_00000030; va = {32'h44, 32'h43, 32'h42, 32'h41};
      wa1 = ka; wd1 = va; we1 = 1'b1;
      tick();
      we1 = 1'b0;
      tick();
      chk_word("t3_k0", 32'h30, 1'b0);
      tick();
      chk_word("t3_k1", 32'h31, 1'b0);
      word_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_word($sformatf("t3_hold%0d", i), 32'h31, 1'b0);
      end
      word_ready = 1'b1;
      tick();
      for (int i = 2; i < 6; i++) begin
         chk_word($sformatf("t3_w%0d", i), ent_word(ka, va, i), (i == 5));
         tick();
      end
      chk("t3_valid_end", {127'd0, word_valid}, 128'd0);

      // 4: fill to 15, then a dual push keeps port-1 only
      word_ready = 1'b0;
      for (int e = 0; e < 15; e++) begin
         wa1 = 64'h100 + 64'(e); wd1 = t4_val(e); we1 = 1'b1;
         tick();
      end
      wa1 = 64'h1FF; wd1 = t4_val(15); wa2 = 64'h2FF; wd2 = t4_val(99); we2 = 1'b1;
      tick();
      we1 = 1'b0; we2 = 1'b0;
      chk("t4_count_full", {123'd0, count}, 128'd16);
      chk("t4_ovf", {127'd0, overflow}, 128'd1);
      wa1 = 64'h3FF; we1 = 1'b1;
      tick();
      we1 = 1'b0;
      chk("t4_count_sat", {123'd0, count}, 128'd16);
      word_ready = 1'b1;
      for (int e = 0; e < 16; e++) begin
         for (int i = 0; i < 6; i++) begin
            chk_word($sformatf("t4_e%0d_w%0d", e, i),
                     ent_word((e == 15) ? 64'h1FF : 64'h100 + 64'(e), t4_val(e), i), (i == 5));
            tick();
         end
      end
      chk("t4_valid_end", {127'd0, word_valid}, 128'd0);
      chk("t4_count_end", {123'd0, count}, 128'd0);
      chk("t4_ovf_sticky", {127'd0, overflow}, 128'd1);

      // 5: clear mid-entry with three entries queued
      word_ready = 1'b0;
      for (int e = 0; e < 3; e++) begin
         wa1 = 64'h70 + 64'(e); wd1 = t4_val(e); we1 = 1'b1;
         tick();
      end
      we1 = 1'b0;
      chk_word("t5_k0", 32'h70, 1'b0);
      chk("t5_count3", {123'd0, count}, 128'd3);
      word_ready = 1'b1;
      tick();
      chk_word("t5_k1", 32'h0, 1'b0);
      clear = 1'b1; wa1 = 64'hBAD; we1 = 1'b1;
      tick();
      clear = 1'b0; we1 = 1'b0;
      chk("t5_valid_clr", {127'd0, word_valid}, 128'd0);
      chk("t5_count_clr", {123'd0, count}, 128'd0);
      chk("t5_ovf_clr", {127'd0, overflow}, 128'd0);
      tick();
      chk("t5_valid_after", {127'd0, word_valid}, 128'd0);
      chk("t5_count_after", {123'd0, count}, 128'd0);
      ka = 64'h00000081_00000080; va = {32'h94, 32'h93, 32'h92, 32'h91};
      wa1 = ka; wd1 = va; we1 = 1'b1;
      tick();
      we1 = 1'b0;
      tick();
      for (int i = 0; i < 6; i++) begin
         chk_word($sformatf("t5_w%0d", i), ent_word(ka, va, i), (i == 5));
         tick();
      end
      chk("t5_valid_end", {127'd0, word_valid}, 128'd0);

      // 6: reset during the value phase
      ka = 64'h90; va = {32'hA4, 32'hA3, 32'hA2, 32'hA1};
      wa1 = ka; wd1 = va; we1 = 1'b1;
      tick();
      we1 = 1'b0;
      tick(); tick(); tick(); tick();
      chk_word("t6_v1", 32'hA2, 1'b0);
      rst_n = 1'b0;
      tick();
      chk("t6_rst_count", {123'd0, count}, 128'd0);
      chk("t6_rst_valid", {127'd0, word_valid}, 128'd0);
      chk("t6_rst_last", {127'd0, word_last}, 128'd0);
      chk("t6_rst_word", {96'd0, word}, 128'd0);
      chk("t6_rst_ovf", {127'd0, overflow}, 128'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("t6_post_valid%0d", i), {127'd0, word_valid}, 128'd0);
         chk($sformatf("t6_post_count%0d", i), {123'd0, count}, 128'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
